// File: rtl/sec_counter_mod60.sv
// Seconds counter, mod 60, held as two BCD digits (tens 0..5, ones 0..9).
// Supports up/down counting, synchronous load with range check, and wrap pulse.
module sec_counter_mod60 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [2:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       zero,
  output logic       load_err
);

  localparam int unsigned TENS_W   = 3;
  localparam int unsigned ONES_W   = 4;
  localparam int unsigned TENS_MAX = 5;
  localparam int unsigned ONES_MAX = 9;

  logic [TENS_W-1:0] tens_q, tens_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              carry_q, carry_d;
  logic              load_err_q, load_err_d;
  logic              load_ok;

  assign load_ok = (load_tens <= TENS_W'(TENS_MAX)) && (load_ones <= ONES_W'(ONES_MAX));

  // Next-state: load beats counting; a rejected load still suppresses the count.
  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        tens_d = load_tens;
        ones_d = load_ones;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (ones_q == ONES_W'(ONES_MAX)) begin
          ones_d = '0;
          if (tens_q == TENS_W'(TENS_MAX)) begin
            tens_d  = '0;
            carry_d = 1'b1;
          end else begin
            tens_d = tens_q + TENS_W'(1);
          end
        end else begin
          ones_d = ones_q + ONES_W'(1);
        end
      end else begin
        if (ones_q == '0) begin
          ones_d = ONES_W'(ONES_MAX);
          if (tens_q == '0) begin
            tens_d  = TENS_W'(TENS_MAX);
            carry_d = 1'b1;
          end else begin
            tens_d = tens_q - TENS_W'(1);
          end
        end else begin
          ones_d = ones_q - ONES_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tens_q     <= '0;
      ones_q     <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;
  assign zero     = (tens_q == '0) && (ones_q == '0);

endmodule

// File: doc/sec_counter_mod60.md
SEC_COUNTER_MOD60 -- requirements
Module: sec_counter_mod60

Interface
REQ-001 The block SHALL have no parameters; digit moduli are fixed at 10 (ones) and 6 (tens).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0), sampled on rising clk.
REQ-004 en  input  1  count enable; one count step per cycle while high.
REQ-005 up_dn  input  1  direction: 1 = count up, 0 = count down; sampled only when en is high.
REQ-006 load  input  1  synchronous load request.
REQ-007 load_tens  input  3  tens digit to load; valid range 0..5.
REQ-008 load_ones  input  4  ones digit to load; valid range 0..9.
REQ-009 tens  output  3  tens digit of the count, range 0..5, registered.
REQ-010 ones  output  4  ones digit of the count, BCD 0..9, registered.
REQ-011 carry  output  1  one-cycle wrap pulse, registered.
REQ-012 zero  output  1  high whenever tens = 0 and ones = 0.
REQ-013 load_err  output  1  one-cycle pulse flagging a rejected load, registered.

Function
REQ-014 Count value SHALL be 10*tens + ones, range 0..59; tens is the downstream stage of ones.
REQ-015 Priority per edge SHALL be: reset > load > en > hold.
REQ-016 Up step (en=1, up_dn=1): ones 0..8 -> ones+1; ones=9 -> ones=0 and tens+1; tens=5 with ones=9 -> 00.
REQ-017 Down step (en=1, up_dn=0): ones 1..9 -> ones-1; ones=0 -> ones=9 and tens-1; 00 -> 59.
REQ-018 carry SHALL be 1 in the cycle after an edge that wrapped 59->00 (up) or 00->59 (down), else 0.
REQ-019 en=0 and load=0 SHALL hold tens and ones unchanged; carry and load_err SHALL be 0.
REQ-020 Valid load (load_tens<=5 and load_ones<=9) SHALL replace tens/ones on that edge; en ignored that cycle; carry=0.
REQ-021 Invalid load (load_tens>5 or load_ones>9) SHALL leave the count unchanged, ignore en that cycle, set load_err=1 for one cycle.
REQ-022 load held high for N cycles SHALL reload/re-check every cycle; load_err repeats per invalid cycle.
REQ-023 zero SHALL be combinational from the registered digits (no added latency).
REQ-024 Output latency SHALL be one clock from sampled inputs to tens/ones/carry/load_err.
REQ-025 tens SHALL never take value 6 or 7 and ones never 10..15 under any input sequence.
REQ-026 Continuous en=1, up_dn=1 from 00 SHALL produce exactly one carry pulse every 60 cycles.
REQ-027 Changing up_dn between enabled cycles SHALL take effect on the next edge with no dead cycle.

Reset
REQ-028 reset=0 at a rising edge SHALL force tens=0, ones=0, carry=0, load_err=0 (zero=1), overriding load and en.
REQ-029 Reset asserted mid-count SHALL take effect at the next edge; no carry SHALL be emitted by that edge.
REQ-030 Behaviour before the first reset edge is undefined; the bench SHALL apply reset=0 for >=1 cycle first.
REQ-031 After reset releases (reset=1), counting SHALL resume on the first edge with en=1.

Verification
REQ-032 Reset: hold reset=0 two cycles with en=1, load=1 -> tens=0, ones=0, zero=1, carry=0, load_err=0.
REQ-033 Up wrap: from 00, en=1, up_dn=1 for 60 cycles -> digits 01,02..09,10..59,00; carry=1 only after 59->00.
REQ-034 Down wrap: load 0/1, then en=1, up_dn=0 -> 00 then 59 with carry=1 on that step, then 58.
REQ-035 Load: load=1, load_tens=4, load_ones=7 with en=1 -> 47 next cycle; invalid 6/3 or 2/12 -> count held, load_err=1 one cycle.
REQ-036 Hold/direction: en=0 for 5 cycles at 23 -> stays 23; toggle up_dn each enabled cycle from 23 -> 24, 23, 24.
REQ-037 Mid-op reset: count to 37, drive reset=0 one edge with en=1 -> 00, carry=0; release -> 01 on next enabled edge.
